// File: rtl/sixteen_way_scan_demux_if.sv
// Handshake bundle for sixteen_way_scan_demux: serial input side and parallel frame output side.
interface sixteen_way_scan_demux_if;
  logic        in_bit;
  logic        in_valid;
  logic        in_ready;
  logic        in_sync;
  logic [3:0]  sel;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  frame_cnt;
  logic        parity_err;

  modport master (
    output in_bit, in_valid, in_sync, out_ready,
    input  in_ready, sel, out_data, out_valid, frame_cnt, parity_err
  );

  modport slave (
    input  in_bit, in_valid, in_sync, out_ready,
    output in_ready, sel, out_data, out_valid, frame_cnt, parity_err
  );
endinterface

// File: rtl/sixteen_way_scan_demux.sv
// Serial-to-parallel 16-way demux with a one-frame holding slot and valid/ready output.
// Optional macro DEMUX_PARITY_EN adds a 17th even-parity bit per frame and drives parity_err.
module sixteen_way_scan_demux #(
  parameter bit MSB_FIRST     = 1'b0,
  parameter bit CLEAR_ON_SYNC = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  sixteen_way_scan_demux_if.slave bus
);

`ifdef DEMUX_PARITY_EN
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned LAST_IDX = 16;
`else
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned LAST_IDX = 15;
`endif
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   work_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic [CNT_W-1:0]    frame_cnt_q;

  logic                accept_c;
  logic                take_c;
  logic                slot_free_c;
  logic                last_c;
  logic [IDX_W-1:0]    idx_c;
  logic [3:0]          ch_c;
  logic [DATA_W-1:0]   work_d;

`ifdef DEMUX_PARITY_EN
  logic parity_err_q;
  logic pend_err_q;
  logic par_err_c;
`endif

  // Merge the incoming bit into the working register at its mapped channel.
  always_comb begin
    accept_c    = bus.in_valid & (state_q == COLLECT);
    take_c      = out_valid_q & bus.out_ready;
    slot_free_c = ~out_valid_q | bus.out_ready;
    idx_c       = bus.in_sync ? '0 : idx_q;
    ch_c        = MSB_FIRST ? 4'(4'd15 - idx_c[3:0]) : idx_c[3:0];
    last_c      = (idx_c == IDX_W'(LAST_IDX));
    work_d      = (bus.in_sync && CLEAR_ON_SYNC) ? '0 : work_q;
`ifdef DEMUX_PARITY_EN
    if (idx_c < IDX_W'(DATA_W)) begin
      work_d[ch_c] = bus.in_bit;
    end
    par_err_c = (^work_d) ^ bus.in_bit;
`else
    work_d[ch_c] = bus.in_bit;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      work_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
`ifdef DEMUX_PARITY_EN
      parity_err_q <= 1'b0;
      pend_err_q   <= 1'b0;
`endif
    end else begin
      // A load below overrides this clear when a new frame lands in the same cycle.
      if (take_c) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        COLLECT: begin
          if (accept_c) begin
            if (last_c) begin
              idx_q <= '0;
              if (slot_free_c) begin
                out_data_q  <= work_d;
                out_valid_q <= 1'b1;
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                work_q      <= '0;
`ifdef DEMUX_PARITY_EN
                parity_err_q <= par_err_c;
`endif
              end else begin
                state_q <= FULL;
                work_q  <= work_d;
`ifdef DEMUX_PARITY_EN
                pend_err_q <= par_err_c;
`endif
              end
            end else begin
              work_q <= work_d;
              idx_q  <= idx_c + IDX_W'(1);
            end
          end else if (bus.in_sync) begin
            idx_q <= '0;
            if (CLEAR_ON_SYNC) begin
              work_q <= '0;
            end
          end
        end
        FULL: begin
          if (slot_free_c) begin
            out_data_q  <= work_q;
            out_valid_q <= 1'b1;
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            work_q      <= '0;
            state_q     <= COLLECT;
`ifdef DEMUX_PARITY_EN
            parity_err_q <= pend_err_q;
`endif
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.sel       = idx_q[3:0];
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_cnt = frame_cnt_q;
`ifdef DEMUX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sixteen_way_scan_demux.sv
// Directed self-checking bench for sixteen_way_scan_demux (default parameters).
module tb_sixteen_way_scan_demux;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   stalls;

  sixteen_way_scan_demux_if bus();

  sixteen_way_scan_demux dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the bit is accepted.
  task automatic send_bit(input logic b, input logic s);
    int n;
    n = 0;
    bus.in_bit   = b;
    bus.in_valid = 1'b1;
    bus.in_sync  = s;
    if (!bus.in_ready) stalls++;
    while (!bus.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_sync = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) send_bit(w[i], 1'b0);
`ifdef DEMUX_PARITY_EN
    send_bit(^w, 1'b0);
`endif
  endtask

  task automatic idle(input int cycles);
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    stalls        = 0;
    reset         = 1'b1;
    bus.in_bit    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sync   = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("rst_sel",       32'(bus.sel),       32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_parity",    32'(bus.parity_err), 32'd0);

    // Normal frame
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1'b1 ^ (i == 2), 1'b0);
    chk("sel_mid", 32'(bus.sel), 32'd3);
    do_reset();
    send_word(16'hA5C3);
    chk("norm_valid", 32'(bus.out_valid), 32'd1);
    chk("norm_data",  32'(bus.out_data),  32'hA5C3);
    chk("norm_cnt",   32'(bus.frame_cnt), 32'd1);
    chk("norm_sel",   32'(bus.sel),       32'd0);
    chk("norm_parity", 32'(bus.parity_err), 32'd0);
    idle(1);
    chk("norm_valid_drop", 32'(bus.out_valid), 32'd0);

    // Backpressure: second frame parks in the working register
    do_reset();
    bus.out_ready = 1'b0;
    send_word(16'h1234);
    chk("bp_first_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_first_data",  32'(bus.out_data),  32'h1234);
    send_word(16'hFFFF);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    idle(3);
    chk("bp_hold_data", 32'(bus.out_data),  32'h1234);
    chk("bp_hold_cnt",  32'(bus.frame_cnt), 32'd1);
    chk("bp_hold_rdy",  32'(bus.in_ready),  32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_rel_data",  32'(bus.out_data),  32'hFFFF);
    chk("bp_rel_cnt",   32'(bus.frame_cnt), 32'd2);
    chk("bp_rel_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_rel_rdy",   32'(bus.in_ready),  32'd1);

    // Resync with in_sync on an accepted bit
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("sync_sel", 32'(bus.sel), 32'd1);
    for (int i = 0; i < 15; i++) send_bit(1'b0, 1'b0);
    chk("sync_valid", 32'(bus.out_valid), 32'd1);
    chk("sync_data",  32'(bus.out_data),  32'h0001);
    chk("sync_cnt",   32'(bus.frame_cnt), 32'd1);

    // Resync with in_sync while idle
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    idle(0);
    bus.in_sync = 1'b1;
    @(negedge clk);
    bus.in_sync = 1'b0;
    chk("idle_sync_sel", 32'(bus.sel), 32'd0);
    send_word(16'h00F0);
    chk("idle_sync_data", 32'(bus.out_data),  32'h00F0);
    chk("idle_sync_cnt",  32'(bus.frame_cnt), 32'd2);

    // Reset mid-frame
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    do_reset();
    chk("mid_rst_sel",   32'(bus.sel),       32'd0);
    chk("mid_rst_data",  32'(bus.out_data),  32'h0);
    chk("mid_rst_cnt",   32'(bus.frame_cnt), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    send_word(16'h8001);
    chk("mid_rst_frame", 32'(bus.out_data),  32'h8001);
    chk("mid_rst_cnt1",  32'(bus.frame_cnt), 32'd1);

`ifdef DEMUX_PARITY_EN
    // Parity: data 0x0003 has even parity 0
    do_reset();
    for (int i = 0; i < 16; i++) send_bit(i < 2, 1'b0);
    chk("par_sel_pbit", 32'(bus.sel), 32'd0);
    send_bit(1'b1, 1'b0);
    chk("par_err_set",  32'(bus.parity_err), 32'd1);
    chk("par_err_data", 32'(bus.out_data),   32'h0003);
    for (int i = 0; i < 16; i++) send_bit(i < 2, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("par_ok",      32'(bus.parity_err), 32'd0);
    chk("par_ok_data", 32'(bus.out_data),   32'h0003);
`endif

    // Counter wrap: 256 back-to-back frames
    do_reset();
    stalls = 0;
    for (int f = 0; f < 256; f++) begin
      send_word(16'(f * 257) ^ 16'h5A5A);
      if (f == 254) begin
        chk("wrap_cnt255",  32'(bus.frame_cnt), 32'd255);
        chk("wrap_data254", 32'(bus.out_data),  32'hA4A4);
      end
    end
    chk("wrap_cnt0",    32'(bus.frame_cnt), 32'd0);
    chk("wrap_data255", 32'(bus.out_data),  32'hA5A5);
    chk("wrap_stalls",  32'(stalls),        32'd0);
    idle(2);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/sixteen_way_scan_demux.md
Name: sixteen_way_scan_demux

Overview:
- Serial-to-parallel demultiplexer; the inverse of the 16:1 mux tree.
- Accepts a bit stream one bit per handshake and steers each bit to output channel `sel` using a free-running 4-bit select counter.
- After 16 bits it delivers the assembled 16-bit word on a valid/ready output port.
- One-word skid holding register plus backpressure; sits between a serial link or mux output and parallel consumers.

Parameters:
- MSB_FIRST, 0, 0: first bit of a frame lands in out_data[0]. 1: first bit lands in out_data[15].
- CLEAR_ON_SYNC, 1, 1: in_sync zeroes the working register. 0: partial bits are left in place and overwritten.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_bit  input  1  serial data bit
- in_valid  input  1  in_bit is valid this cycle
- in_ready  output  1  block can accept in_bit this cycle
- in_sync  input  1  marks in_bit (or the next accepted bit) as channel 0 of a new frame
- sel  output  4  channel index the next accepted bit will be written to (register value, before MSB_FIRST mapping)
- out_data  output  16  assembled frame
- out_valid  output  1  out_data holds an undelivered frame
- out_ready  input  1  consumer takes out_data when out_valid is high
- frame_cnt  output  8  frames delivered, wraps 255->0
- parity_err  output  1  parity flag for the current out_data (see Optional Feature)

Behaviour:
- Reset, synchronous, overrides everything:
  - sel=0, working reg=0, out_data=0, out_valid=0, frame_cnt=0, parity_err=0.
  - FSM=COLLECT.
  - Reset mid-frame discards all partial data.
- Accept condition: accept = in_valid & in_ready. Delivery condition: take = out_valid & out_ready.
- FSM states: COLLECT and FULL.
  - COLLECT: in_ready=1.
  - FULL: in_ready=0. The working reg holds a complete frame that is waiting for the output slot.
- COLLECT, on accept:
  - Index = (in_sync ? 0 : sel). Mapped channel = MSB_FIRST ? 15-index : index.
  - The working bit at the mapped channel is set to in_bit.
  - sel <= index+1, 4-bit wrap.
- COLLECT, in_sync without accept: sel<=0. The working reg is cleared if CLEAR_ON_SYNC=1.
- Frame completes when the accepted bit has index 15 (index 16 under parity).
- On frame completion:
  - If !out_valid or take in the same cycle:
    - out_data <= working reg with the final bit merged.
    - out_valid stays/goes 1; frame_cnt++.
    - sel<=0; working reg cleared; stay in COLLECT.
  - Otherwise: go to FULL, sel<=0, working reg keeps the frame.
- FULL:
  - When !out_valid or take: out_data <= working reg, out_valid=1, frame_cnt++, working reg cleared, go to COLLECT.
  - in_ready returns high the cycle after the transfer.
  - in_sync is ignored in FULL.
- out_valid clears on take when no new frame loads in that cycle.
- out_data is stable while out_valid=1 and !out_ready.
- Latency: final bit accepted at edge N gives out_valid=1 and new out_data visible after edge N. Zero bubbles between frames when out_ready=1.
- Throughput: 1 bit/cycle sustained.
- Wrap behaviour:
  - sel wraps 15->0 only via frame completion.
  - frame_cnt wraps 255->0.
- All outputs registered except in_ready, which is decoded from the FSM state.

Optional Feature:
- Macro: DEMUX_PARITY_EN.
- Defined:
  - Frame is 17 bits; the 17th accepted bit (index 16) is even parity over the 16 data bits.
  - An internal 5-bit index is used; sel reports its low 4 bits, and reads 0 during the parity bit.
  - parity_err is registered alongside out_data: 1 when the XOR of 16 data bits and parity bit ≠ 0. It updates with every out_data load.
  - The parity bit is never written to out_data.
- Undefined: frame is 16 bits; parity_err is constant 0.

Test Plan:
- Normal frame: reset, then 16 bits of 16'hA5C3 LSB-first, out_ready=1 -> out_valid=1 for one cycle after 16th accept, out_data=16'hA5C3, frame_cnt=1, sel=0.
- Backpressure: out_ready=0, send 16'h1234 then 16'hFFFF -> in_ready=0 after 2nd frame, out_data holds 16'h1234. Raise out_ready for one cycle -> out_data=16'hFFFF, frame_cnt=2, in_ready=1 next cycle.
- Resync: 5 bits of 1, then in_sync with in_bit=1, then 15 zeros -> out_data=16'h0001 (CLEAR_ON_SYNC=1).
- Reset mid-frame: reset after 7 accepted bits -> all outputs zero; next 16 bits of 16'h8001 give out_data=16'h8001, frame_cnt=1.
- Counter wrap: 256 back-to-back frames with out_ready=1 -> frame_cnt=0, no in_ready drop.
- Parity, DEMUX_PARITY_EN defined: 16'h0003 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0, out_data=16'h0003.
